// File: rtl/alu_mc_if.sv
// Operand-issue / writeback bundle for the multi-cycle ALU.
// The issue side owns the master modport, and the ALU owns the slave modport.
interface alu_mc_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [3:0]            FuncCode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] C;
    logic                  OverflowFlag;
    logic                  ovf_sticky;
    logic                  ovf_clear;

    modport master (
        output in_valid, A, B, FuncCode, out_ready, ovf_clear,
        input  in_ready, out_valid, C, OverflowFlag, ovf_sticky
    );

    modport slave (
        input  in_valid, A, B, FuncCode, out_ready, ovf_clear,
        output in_ready, out_valid, C, OverflowFlag, ovf_sticky
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle 16-function ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle, and a sticky overflow flag collects overflow across results.
module alu_mc #(
    parameter int DATA_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_mc_if.slave   bus
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {MSB{1'b0}}};

    typedef enum logic [3:0] {
        F_ADD, F_SUB, F_TCP, F_ZERO, F_ID, F_NOT, F_AND, F_OR,
        F_NAND, F_NOR, F_XOR, F_XNOR, F_LLS, F_LRS, F_ALS, F_ARS
    } func_e;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_e;

    state_e                state_q, state_nxt;
    func_e                 func_q;
    logic [DATA_WIDTH-1:0] res_q, res_nxt;
    logic                  ovf_q, ovf_nxt;
    logic [SHW-1:0]        cnt_q, cnt_nxt;
    logic                  sticky_q;

    func_e                 func_in;
    logic [SHW-1:0]        amt;
    logic                  accept;
    logic                  in_is_shift;
    logic [DATA_WIDTH-1:0] sum, diff, op_res, step_res;
    logic                  op_ovf, step_ovf;

    assign func_in     = func_e'(bus.FuncCode);
    assign amt         = bus.B[SHW-1:0];
    assign accept      = bus.in_valid && (state_q == S_IDLE);
    assign in_is_shift = (func_in == F_LLS) || (func_in == F_LRS) ||
                         (func_in == F_ALS) || (func_in == F_ARS);
    assign sum         = bus.A + bus.B;
    assign diff        = bus.A - bus.B;

    // Single-cycle result. A shift by zero returns A unchanged.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        unique case (func_in)
            F_ADD:  begin
                op_res = sum;
                op_ovf = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
            end
            F_SUB:  begin
                op_res = diff;
                op_ovf = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
            end
            F_TCP:  begin
                op_res = -bus.A;
                op_ovf = (bus.A == MIN_NEG);
            end
            F_ZERO: op_res = '0;
            F_NOT:  op_res = ~bus.A;
            F_AND:  op_res = bus.A & bus.B;
            F_OR:   op_res = bus.A | bus.B;
            F_NAND: op_res = ~(bus.A & bus.B);
            F_NOR:  op_res = ~(bus.A | bus.B);
            F_XOR:  op_res = bus.A ^ bus.B;
            F_XNOR: op_res = ~(bus.A ^ bus.B);
            default: op_res = bus.A;  // F_ID, or a shift by zero
        endcase
    end

    // One-position shift step. ALS flags overflow whenever the sign bit would change.
    always_comb begin
        step_res = res_q;
        step_ovf = 1'b0;
        case (func_q)
            F_LLS: step_res = {res_q[MSB-1:0], 1'b0};
            F_LRS: step_res = {1'b0, res_q[MSB:1]};
            F_ALS: begin
                step_res = {res_q[MSB-1:0], 1'b0};
                step_ovf = res_q[MSB] ^ res_q[MSB-1];
            end
            F_ARS: step_res = {res_q[MSB], res_q[MSB:1]};
            default: step_res = res_q;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        res_nxt   = res_q;
        ovf_nxt   = ovf_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (in_is_shift && (amt != '0)) begin
                    res_nxt   = bus.A;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = amt;
                    state_nxt = S_SHIFT;
                end else begin
                    res_nxt   = op_res;
                    ovf_nxt   = op_ovf;
                    state_nxt = S_HOLD;
                end
            end
            S_SHIFT: begin
                res_nxt = step_res;
                ovf_nxt = ovf_q | step_ovf;
                cnt_nxt = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) state_nxt = S_HOLD;
            end
            S_HOLD: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            func_q   <= F_ADD;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            res_q   <= res_nxt;
            ovf_q   <= ovf_nxt;
            cnt_q   <= cnt_nxt;
            if (accept) func_q <= func_in;
            // When the clear request and a new overflow arrive in the same cycle, the set takes priority.
            if ((state_q == S_HOLD) && bus.out_ready && ovf_q) sticky_q <= 1'b1;
            else if (bus.ovf_clear)                             sticky_q <= 1'b0;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_HOLD);
    assign bus.C            = res_q;
    assign bus.OverflowFlag = ovf_q;
    assign bus.ovf_sticky   = sticky_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc, run at DATA_WIDTH 16 and 32.
// Expected results are queued at issue time and compared when each result is handed off.
module tb_alu_mc;
    localparam logic [3:0] F_ADD = 4'd0,  F_SUB = 4'd1,  F_TCP = 4'd2,  F_ZERO = 4'd3;
    localparam logic [3:0] F_LLS = 4'd12, F_LRS = 4'd13, F_ALS = 4'd14, F_ARS  = 4'd15;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_mc_if #(.DATA_WIDTH(16)) i16 ();
    alu_mc_if #(.DATA_WIDTH(32)) i32 ();

    alu_mc #(.DATA_WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(i16.slave));
    alu_mc #(.DATA_WIDTH(32)) u32 (.clk(clk), .reset_n(reset_n), .bus(i32.slave));

    int          tests = 0;
    int          fails = 0;
    logic        st16  = 1'b0;
    logic        st32  = 1'b0;
    logic [32:0] sb[$];

    task automatic set_in(int w, logic v, logic [3:0] f, logic [31:0] a, logic [31:0] b);
        if (w == 16) begin
            i16.in_valid = v; i16.FuncCode = f; i16.A = a[15:0]; i16.B = b[15:0];
        end else begin
            i32.in_valid = v; i32.FuncCode = f; i32.A = a; i32.B = b;
        end
    endtask

    task automatic set_hs(int w, logic ordy, logic clr);
        if (w == 16) begin i16.out_ready = ordy; i16.ovf_clear = clr; end
        else         begin i32.out_ready = ordy; i32.ovf_clear = clr; end
    endtask

    task automatic get(int w, output logic ir, output logic ov, output logic ovf,
                       output logic st, output logic [31:0] c);
        if (w == 16) begin
            ir = i16.in_ready; ov = i16.out_valid; ovf = i16.OverflowFlag;
            st = i16.ovf_sticky; c = {16'h0, i16.C};
        end else begin
            ir = i32.in_ready; ov = i32.out_valid; ovf = i32.OverflowFlag;
            st = i32.ovf_sticky; c = i32.C;
        end
    endtask

    // Reference model: returns {ovf, result}.
    function automatic logic [32:0] model(int w, logic [3:0] f, logic [31:0] a_in, logic [31:0] b_in);
        logic [31:0] mask, a, b, r, top;
        int m, n;
        logic o;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a_in & mask; b = b_in & mask;
        m = w - 1; n = int'(b) & (w - 1);
        top = 32'd1 << m;
        r = 32'd0; o = 1'b0;
        case (f)
            4'd0:  begin r = (a + b) & mask; o = (a[m] == b[m]) && (r[m] != a[m]); end
            4'd1:  begin r = (a - b) & mask; o = (a[m] != b[m]) && (r[m] != a[m]); end
            4'd2:  begin r = (~a + 32'd1) & mask; o = (a == top); end
            4'd3:  r = 32'd0;
            4'd4:  r = a;
            4'd5:  r = ~a & mask;
            4'd6:  r = a & b;
            4'd7:  r = a | b;
            4'd8:  r = ~(a & b) & mask;
            4'd9:  r = ~(a | b) & mask;
            4'd10: r = a ^ b;
            4'd11: r = ~(a ^ b) & mask;
            4'd12: r = (a << n) & mask;
            4'd13: r = a >> n;
            4'd14: begin
                r = (a << n) & mask;
                for (int i = 1; i <= n; i++) if (a[m-i] != a[m]) o = 1'b1;
            end
            default: begin
                r = a;
                for (int i = 0; i < n; i++) r = (r >> 1) | (r & top);
            end
        endcase
        return {o, r};
    endfunction

    // Issue one operation, check latency and result, hand it off, and check the sticky flag.
    task automatic test_op(int w, logic [3:0] f, logic [31:0] a, logic [31:0] b,
                           logic clr, string name);
        logic [32:0] e, got;
        logic        ir, ov, ovf, st, busy_err, st_exp;
        logic [31:0] c;
        int          n, exp_lat, cyc;
        e = model(w, f, a, b);
        n = int'(b) & (w - 1);
        exp_lat = (f >= 4'd12 && n != 0) ? n + 1 : 1;
        get(w, ir, ov, ovf, st, c);
        tests++;
        if (ir !== 1'b1) begin fails++; $display("FAIL %s ready: in_ready=%b want 1", name, ir); end
        set_in(w, 1'b1, f, a, b);
        sb.push_back(e);
        @(posedge clk);
        cyc = 0; busy_err = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) set_in(w, 1'b0, 4'd0, 32'd0, 32'd0);
            get(w, ir, ov, ovf, st, c);
            if (ir !== 1'b0) busy_err = 1'b1;
        end while (ov !== 1'b1 && cyc < 100);
        got = sb.pop_front();
        tests++;
        if (ov !== 1'b1) begin
            fails++; $display("FAIL %s timeout: out_valid=%b after %0d cycles", name, ov, cyc);
            return;
        end
        if (cyc != exp_lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat); end
        tests++;
        if (busy_err) begin fails++; $display("FAIL %s busy: in_ready=1 while op in flight, want 0", name); end
        tests++;
        if (c !== got[31:0] || ovf !== got[32]) begin
            fails++;
            $display("FAIL %s result: C=%h ovf=%b want C=%h ovf=%b", name, c, ovf, got[31:0], got[32]);
        end
        set_hs(w, 1'b1, clr);
        @(posedge clk);
        @(negedge clk);
        set_hs(w, 1'b0, 1'b0);
        if (w == 16) begin
            if (got[32]) st16 = 1'b1; else if (clr) st16 = 1'b0;
            st_exp = st16;
        end else begin
            if (got[32]) st32 = 1'b1; else if (clr) st32 = 1'b0;
            st_exp = st32;
        end
        get(w, ir, ov, ovf, st, c);
        tests++;
        if (ir !== 1'b1 || ov !== 1'b0 || st !== st_exp) begin
            fails++;
            $display("FAIL %s handoff: in_ready=%b out_valid=%b sticky=%b want 1 0 %b", name, ir, ov, st, st_exp);
        end
    endtask

    task automatic test_reset();
        logic ir, ov, ovf, st;
        logic [31:0] c;
        for (int k = 0; k < 2; k++) begin
            get(k == 0 ? 16 : 32, ir, ov, ovf, st, c);
            tests++;
            if (ir !== 1'b1 || ov !== 1'b0 || ovf !== 1'b0 || st !== 1'b0 || c !== 32'd0) begin
                fails++;
                $display("FAIL reset_%0d: ir=%b ov=%b ovf=%b st=%b C=%h want 1 0 0 0 0", k, ir, ov, ovf, st, c);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith(int w);
        logic [31:0] maxp;
        maxp = (w == 16) ? 32'h7FFF : 32'h7FFF_FFFF;
        test_op(w, F_ADD, maxp, 32'd1, 1'b0, "add_ovf");
        test_op(w, F_ADD, 32'd5, 32'd7, 1'b0, "add_plain");
        test_op(w, F_ZERO, 32'h1234, 32'h5678, 1'b0, "zero");
    endtask

    task automatic test_shift(int w);
        logic [31:0] hi, s1, mn;
        hi = (w == 16) ? 32'h4000 : 32'h4000_0000;
        mn = (w == 16) ? 32'h8000 : 32'h8000_0000;
        s1 = 32'(w - 1);
        test_op(w, F_LLS, 32'h0001, 32'h0004, 1'b0, "lls4");
        test_op(w, F_ALS, hi, 32'd1, 1'b0, "als_ovf");
        test_op(w, F_ARS, mn, s1, 1'b0, "ars_max");
        test_op(w, F_LRS, 32'h1234, 32'd0, 1'b0, "lrs0");
    endtask

    task automatic test_backpressure();
        logic [32:0] e, got;
        logic ir, ov, ovf, st;
        logic [31:0] c;
        e = model(16, F_SUB, 32'h8000, 32'h0001);
        set_in(16, 1'b1, F_SUB, 32'h8000, 32'h0001);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        set_in(16, 1'b1, F_ADD, 32'h0003, 32'h0003);
        get(16, ir, ov, ovf, st, c);
        got = sb.pop_front();
        tests++;
        if (ov !== 1'b1) begin fails++; $display("FAIL bp_valid: out_valid=%b want 1", ov); end
        for (int k = 0; k < 3; k++) begin
            get(16, ir, ov, ovf, st, c);
            tests++;
            if (ov !== 1'b1 || ir !== 1'b0 || c !== got[31:0] || ovf !== got[32]) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b C=%h ovf=%b want 1 0 %h %b", k, ov, ir, c, ovf, got[31:0], got[32]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        set_in(16, 1'b0, 4'd0, 32'd0, 32'd0);
        set_hs(16, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_hs(16, 1'b0, 1'b0);
        st16 = 1'b1;
        get(16, ir, ov, ovf, st, c);
        tests++;
        if (ir !== 1'b1 || ov !== 1'b0 || st !== st16) begin
            fails++; $display("FAIL bp_release: ir=%b ov=%b st=%b want 1 0 1", ir, ov, st);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic ir, ov, ovf, st, bad;
        logic [31:0] c;
        set_in(16, 1'b1, F_LLS, 32'h0001, 32'h0008);
        sb.push_back(model(16, F_LLS, 32'h0001, 32'h0008));
        @(posedge clk);
        @(negedge clk);
        set_in(16, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        st16 = 1'b0; st32 = 1'b0;
        get(16, ir, ov, ovf, st, c);
        tests++;
        if (ir !== 1'b1 || ov !== 1'b0 || st !== 1'b0 || c !== 32'd0) begin
            fails++; $display("FAIL rst_async: ir=%b ov=%b st=%b C=%h want 1 0 0 0", ir, ov, st, c);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            get(16, ir, ov, ovf, st, c);
            if (ov !== 1'b0 || ir !== 1'b1 || st !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL rst_after: ir=%b ov=%b st=%b want 1 0 0", ir, ov, st); end
    endtask

    task automatic test_sticky_clear();
        logic ir, ov, ovf, st;
        logic [31:0] c;
        test_op(16, F_TCP, 32'h8000, 32'd0, 1'b1, "tcp_set_wins");
        set_hs(16, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_hs(16, 1'b0, 1'b0);
        st16 = 1'b0;
        get(16, ir, ov, ovf, st, c);
        tests++;
        if (st !== st16) begin fails++; $display("FAIL sticky_clear: sticky=%b want 0", st); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [3:0] f;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            w = (i % 2 == 1) ? 32 : 16;
            f = 4'($urandom_range(0, 15));
            b = (f >= 4'd12) ? 32'($urandom_range(0, w - 1)) : $urandom;
            test_op(w, f, $urandom, b, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(16, 1'b0, 4'd0, 32'd0, 32'd0);
        set_in(32, 1'b0, 4'd0, 32'd0, 32'd0);
        set_hs(16, 1'b0, 1'b0);
        set_hs(32, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_arith(16);
        test_shift(16);
        test_backpressure();
        test_reset_mid_shift();
        test_sticky_clear();
        test_arith(32);
        test_shift(32);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
